// File: rtl/dac_threshold_wr.sv
// rtl/dac_threshold_wr.sv - SPI writer for the comparator threshold DAC with settle wait and a one-deep pending slot
// Optional LDAC pulse after chip-select release: define DAC_LDAC_EN.
module dac_threshold_wr #(
    parameter int CLK_DIV       = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int LDAC_CYCLES   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] threshold_i,
    input  logic        threshold_wre_i,
    output logic        threshold_rdy_o,
    output logic [15:0] dac_code_o,
    output logic        dac_cs_n_o,
    output logic        dac_sclk_o,
`ifdef DAC_LDAC_EN
    output logic        dac_ldac_n_o,
`endif
    output logic        dac_mosi_o
);

    // A zero settle time still needs one chip-select-high cycle when a pending write chains on.
    localparam int SETTLE_LEN = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
    localparam int MAX_A      = (CLK_DIV > SETTLE_LEN) ? CLK_DIV : SETTLE_LEN;
    localparam int MAXC       = (MAX_A > LDAC_CYCLES) ? MAX_A : LDAC_CYCLES;
    localparam int CW         = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
`ifdef DAC_LDAC_EN
        S_LDAC,
`endif
        S_SETTLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          sclk_hi_q;
    logic [3:0]    bit_cnt_q;
    logic          last_q;
    logic [15:0]   code_q;
    logic [15:0]   dac_code_q;
    logic          pend_q;
    logic [15:0]   pend_code_q;

    logic          div_last;
    logic          settle_last;
    logic          load_new;
    logic          take_pend;
    logic          publish;
    state_t        post_cs;

    assign div_last    = (cnt_q == CW'(CLK_DIV - 1));
    assign settle_last = (cnt_q == CW'(SETTLE_LEN - 1));

    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        take_pend = 1'b0;
        publish   = 1'b0;
        post_cs   = ((SETTLE_CYCLES != 0) || pend_q || threshold_wre_i) ? S_SETTLE : S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (threshold_wre_i) begin
                    load_new = 1'b1;
                    state_d  = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (div_last) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_last && !sclk_hi_q && last_q) state_d = S_CS_HOLD;
            end
            S_CS_HOLD: begin
                if (div_last) begin
                    publish = 1'b1;
`ifdef DAC_LDAC_EN
                    state_d = S_LDAC;
`else
                    state_d = post_cs;
`endif
                end
            end
`ifdef DAC_LDAC_EN
            S_LDAC: begin
                if (cnt_q == CW'(LDAC_CYCLES - 1)) state_d = post_cs;
            end
`endif
            S_SETTLE: begin
                if (settle_last) begin
                    if (pend_q || threshold_wre_i) begin
                        take_pend = 1'b1;
                        state_d   = S_CS_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sclk_hi_q   <= 1'b0;
            bit_cnt_q   <= 4'd15;
            last_q      <= 1'b0;
            code_q      <= '0;
            dac_code_q  <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE || state_d != state_q || (state_q == S_SHIFT && div_last))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CW'(1);

            if (load_new || take_pend) begin
                code_q    <= (load_new || threshold_wre_i) ? threshold_i : pend_code_q;
                bit_cnt_q <= 4'd15;
                last_q    <= 1'b0;
                sclk_hi_q <= 1'b1;
            end else if (state_q == S_SHIFT && div_last) begin
                sclk_hi_q <= ~sclk_hi_q;
                // Data moves on the falling edge; the counter stops at 0 and last_q marks the tail.
                if (sclk_hi_q) begin
                    if (bit_cnt_q != 4'd0) bit_cnt_q <= bit_cnt_q - 4'd1;
                    else                   last_q    <= 1'b1;
                end
            end

            if (publish) dac_code_q <= code_q;

            if (take_pend) begin
                pend_q <= 1'b0;
            end else if (threshold_wre_i && state_q != S_IDLE) begin
                pend_q      <= 1'b1;
                pend_code_q <= threshold_i;
            end
        end
    end

    assign threshold_rdy_o = (state_q == S_IDLE);
    assign dac_code_o      = dac_code_q;
    assign dac_cs_n_o      = !(state_q == S_CS_SETUP || state_q == S_SHIFT || state_q == S_CS_HOLD);
    assign dac_sclk_o      = (state_q == S_SHIFT) && sclk_hi_q;
    assign dac_mosi_o      = (state_q == S_CS_SETUP || (state_q == S_SHIFT && !last_q)) ?
                             code_q[bit_cnt_q] : 1'b0;
`ifdef DAC_LDAC_EN
    assign dac_ldac_n_o    = (state_q != S_LDAC);
`endif

endmodule

// File: tb/tb_dac_threshold_wr.sv
// tb/tb_dac_threshold_wr.sv - scoreboard bench for dac_threshold_wr
module tb_dac_threshold_wr;

`ifdef DAC_LDAC_EN
    localparam int LD = 2;
`else
    localparam int LD = 0;
`endif
    localparam int LAT = 168 + LD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_thr = '0;
    logic        a_wre = 1'b0;
    logic        a_rdy, a_cs_n, a_sclk, a_mosi;
    logic [15:0] a_code;
    logic [15:0] b_thr = '0;
    logic        b_wre = 1'b0;
    logic        b_rdy, b_cs_n, b_sclk, b_mosi;
    logic [15:0] b_code;
`ifdef DAC_LDAC_EN
    logic        a_ldac_n, b_ldac_n;
`endif

    always #5 clk = ~clk;

    dac_threshold_wr u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .threshold_i(a_thr), .threshold_wre_i(a_wre), .threshold_rdy_o(a_rdy),
        .dac_code_o(a_code), .dac_cs_n_o(a_cs_n), .dac_sclk_o(a_sclk),
`ifdef DAC_LDAC_EN
        .dac_ldac_n_o(a_ldac_n),
`endif
        .dac_mosi_o(a_mosi)
    );

    dac_threshold_wr #(.CLK_DIV(1), .SETTLE_CYCLES(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .threshold_i(b_thr), .threshold_wre_i(b_wre), .threshold_rdy_o(b_rdy),
        .dac_code_o(b_code), .dac_cs_n_o(b_cs_n), .dac_sclk_o(b_sclk),
`ifdef DAC_LDAC_EN
        .dac_ldac_n_o(b_ldac_n),
`endif
        .dac_mosi_o(b_mosi)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [15:0] sb_q[$];
    bit          pend_valid = 0;
    bit          drop_frame = 0;
    int          frames = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model of the one-deep pending slot: a busy write replaces a not-yet-started frame.
    task automatic sb_write(input logic [15:0] code, input bit busy);
        if (!busy) begin
            sb_q.push_back(code);
        end else if (pend_valid) begin
            sb_q[sb_q.size()-1] = code;
        end else begin
            sb_q.push_back(code);
            pend_valid = 1;
        end
    endtask

    logic [15:0] mon_cap = '0;
    int          mon_bits = 0;
    logic        mon_prev_cs_n = 1'b1;
    logic        mon_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (mon_prev_cs_n && !a_cs_n) begin
            mon_cap  = '0;
            mon_bits = 0;
        end
        if (!a_cs_n && !mon_prev_sclk && a_sclk) begin
            mon_cap = {mon_cap[14:0], a_mosi};
            mon_bits++;
        end
        if (!mon_prev_cs_n && a_cs_n) begin
            if (drop_frame) begin
                drop_frame = 0;
            end else if (sb_q.size() == 0) begin
                check_val("frame_unexpected", mon_cap, 32'hDEAD_BEEF);
            end else begin
                check_val("frame_code", mon_cap, sb_q.pop_front());
                check_val("frame_bits", mon_bits, 16);
                frames++;
            end
        end
        mon_prev_cs_n = a_cs_n;
        mon_prev_sclk = a_sclk;
    end

    initial begin
        int first_rdy, first_cs, last_cs, f0;
        int b_rises, b_run, b_maxrun;
        logic [15:0] b_cap;
        logic b_prev;
`ifdef DAC_LDAC_EN
        int ld_first, ld_cnt;
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rst_rdy", a_rdy, 1);
        check_val("rst_cs_n", a_cs_n, 1);
        check_val("rst_sclk", a_sclk, 0);
        check_val("rst_mosi", a_mosi, 0);
        check_val("rst_code", a_code, 16'h0000);

        // single write, default timing
        a_thr = 16'hA5C3; a_wre = 1'b1; sb_write(16'hA5C3, 0);
        first_rdy = 0; first_cs = 0; last_cs = 0;
`ifdef DAC_LDAC_EN
        ld_first = 0; ld_cnt = 0;
`endif
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check_val("start_rdy_low", a_rdy, 0);
                check_val("start_mosi_msb", a_mosi, 1);
            end
            if (n == 67) check_val("hold_mosi_zero", a_mosi, 0);
            if (n == 68) check_val("code_before_cs_rise", a_code, 16'h0000);
            if (n == 69) check_val("code_at_cs_rise", a_code, 16'hA5C3);
            if (!a_cs_n) begin
                if (first_cs == 0) first_cs = n;
                last_cs = n;
            end
            if (a_rdy && first_rdy == 0) first_rdy = n;
`ifdef DAC_LDAC_EN
            if (!a_ldac_n) begin
                if (ld_first == 0) ld_first = n;
                ld_cnt++;
            end
`endif
            a_wre = 1'b0;
        end
        check_val("cs_first_low", first_cs, 1);
        check_val("cs_last_low", last_cs, 68);
        check_val("single_rdy_rise", first_rdy, 1 + LAT);
        check_val("single_sb_empty", sb_q.size(), 0);
`ifdef DAC_LDAC_EN
        check_val("ldac_first", ld_first, 69);
        check_val("ldac_width", ld_cnt, 2);
`endif

        // last write wins while busy
        f0 = frames; first_rdy = 0; pend_valid = 0;
        a_thr = 16'h1111; a_wre = 1'b1; sb_write(16'h1111, 0);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (a_rdy && first_rdy == 0) first_rdy = n;
            a_wre = (n == 20 || n == 40);
            a_thr = (n == 20) ? 16'h2222 : 16'h3333;
            if (a_wre) sb_write(a_thr, 1);
        end
        pend_valid = 0;
        check_val("chain_rdy_rise", first_rdy, 2 * LAT + 1);
        check_val("chain_frames", frames - f0, 2);
        check_val("chain_code", a_code, 16'h3333);
        check_val("chain_sb_empty", sb_q.size(), 0);

        // fastest configuration, no settle wait
        b_thr = 16'hFFFF; b_wre = 1'b1;
        first_rdy = 0; b_rises = 0; b_run = 0; b_maxrun = 0; b_cap = '0; b_prev = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (b_sclk && !b_prev) begin
                b_rises++;
                b_cap = {b_cap[14:0], b_mosi};
            end
            b_run = b_sclk ? b_run + 1 : 0;
            if (b_run > b_maxrun) b_maxrun = b_run;
            if (b_rdy && first_rdy == 0) first_rdy = n;
            b_prev = b_sclk;
            b_wre = 1'b0;
        end
        check_val("fast_rdy_rise", first_rdy, 35 + LD);
        check_val("fast_sclk_rises", b_rises, 16);
        check_val("fast_sclk_width", b_maxrun, 1);
        check_val("fast_bits", b_cap, 16'hFFFF);
        check_val("fast_code", b_code, 16'hFFFF);

        // reset in the 8th SCLK period aborts the frame
        a_thr = 16'h00FF; a_wre = 1'b1; sb_write(16'h00FF, 0);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            a_wre = 1'b0;
            if (n == 32) begin
                check_val("abort_sclk_high", a_sclk, 1);
                drop_frame = 1;
                sb_q.delete();
                rst = 1'b1;
            end
        end
        @(negedge clk);
        check_val("abort_cs_n", a_cs_n, 1);
        check_val("abort_sclk", a_sclk, 0);
        check_val("abort_rdy", a_rdy, 1);
        check_val("abort_code", a_code, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        a_thr = 16'h0F0F; a_wre = 1'b1; sb_write(16'h0F0F, 0);
        first_rdy = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (a_rdy && first_rdy == 0) first_rdy = n;
            a_wre = 1'b0;
        end
        check_val("after_abort_rdy_rise", first_rdy, 1 + LAT);
        check_val("after_abort_code", a_code, 16'h0F0F);
        check_val("after_abort_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_threshold_wr.md
Name: dac_threshold_wr

Overview:
- Responder side of the threshold handshake (`threshold_o` / `threshold_wre_o` / `threshold_rdy_i`) driven by the channel measurement controller.
- Accepts 16-bit threshold codes and serialises them MSB-first over SPI to the comparator threshold DAC.
- Waits a programmable analog settle time, then reports ready so the controller can sample the comparator against a stable threshold.
- Holds at most one pending code; while busy, the last write wins.

Parameters:
- CLK_DIV, 2: SCLK half-period in `clk_i` cycles; legal range ≥1.
- SETTLE_CYCLES, 100: analog settle wait after CS deassert, before ready; 0 is legal and means no wait.
- LDAC_CYCLES, 2: LDAC low-pulse width in `clk_i` cycles; used only when `DAC_LDAC_EN` is defined.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- threshold_i  input  16  DAC code from the controller
- threshold_wre_i  input  1  single-cycle write strobe
- threshold_rdy_o  output  1  high: DAC idle and settled
- dac_code_o  output  16  code most recently written to the DAC (updated at CS deassert)
- dac_cs_n_o  output  1  SPI chip select, active-low
- dac_sclk_o  output  1  SPI clock, idle low
- dac_mosi_o  output  1  SPI data
- dac_ldac_n_o  output  1  DAC load strobe; present only with `DAC_LDAC_EN`

Behaviour:
- Reset values (state after any cycle with `rst_i` high):
  - `threshold_rdy_o`=1, `dac_cs_n_o`=1, `dac_sclk_o`=0, `dac_mosi_o`=0, `dac_code_o`=0, `dac_ldac_n_o`=1.
  - Pending flag cleared; state=IDLE.
  - Reset mid-transfer aborts with no tail clocks. CS is high the cycle after reset is sampled.
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → [LDAC] → SETTLE → IDLE.
- IDLE:
  - `threshold_rdy_o`=1.
  - `threshold_wre_i` sampled high: latch `threshold_i` into the shift register and go to CS_SETUP.
  - From the next cycle: `rdy`=0, `cs_n`=0, `mosi`=bit15.
- CS_SETUP:
  - Lasts CLK_DIV cycles; SCLK low.
- SHIFT:
  - 16 SCLK periods. Each period: SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - MOSI is stable across each rising edge. It advances to the next bit on the SCLK falling edge, MSB first.
  - After the 16th falling edge, go to CS_HOLD. MOSI returns to 0.
- CS_HOLD:
  - Lasts CLK_DIV cycles with `cs_n`=0.
  - Then `cs_n`=1 and `dac_code_o` ← transmitted code.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then goes to IDLE with `rdy`=1.
  - SETTLE_CYCLES=0: IDLE is entered on the cycle after CS_HOLD ends.
- Latency without LDAC:
  - wre sampled at cycle 0 → `rdy` high at cycle 1 + 34·CLK_DIV + SETTLE_CYCLES.
  - Defaults: `rdy` rises at cycle 169 and stays low for 168 cycles.
- Write while busy (`rdy`=0):
  - Code captured into the pending register and pending flag set; later writes overwrite it.
  - At end of SETTLE with pending set: clear the flag and start a new transfer directly in CS_SETUP. `rdy` stays 0, so there is no ready glitch.
- Write in the same cycle as the SETTLE→IDLE transition: treated as a pending write, same result as above.
- No write is ever dropped except one overwritten by a newer write.
- Counters are sized `$clog2` of the maximum count +1, with no wrap.
- The bit counter is 4 bits: counts 15 down to 0, then terminal.

Optional Feature:
- Macro: `DAC_LDAC_EN`.
- Defined:
  - `dac_ldac_n_o` port exists.
  - After CS_HOLD, an LDAC state drives `dac_ldac_n_o`=0 for LDAC_CYCLES cycles.
  - SETTLE starts after the pulse; latency grows by LDAC_CYCLES.
- Undefined:
  - Port and LDAC state are absent.
  - The DAC updates on CS rising edge (auto-update mode); timing is as in Behaviour.

Test Plan:
- Reset then idle 10 cycles → `rdy`=1, `cs_n`=1, `sclk`=0, `mosi`=0, `dac_code_o`=0x0000.
- Defaults, single write 0xA5C3 at cycle 0:
  - Bits captured on 16 SCLK rising edges = 1010_0101_1100_0011.
  - `cs_n` low cycles 1–68.
  - `rdy` rises at cycle 169; `dac_code_o`=0xA5C3 from cycle 69.
- Write 0x1111, then 0x2222 at cycle 20 and 0x3333 at cycle 40 (both busy):
  - Exactly two SPI frames: 0x1111, then 0x3333.
  - `rdy` stays 0 between frames.
  - Final `dac_code_o`=0x3333.
- SETTLE_CYCLES=0, CLK_DIV=1: write 0xFFFF → `rdy` back high at cycle 35; 16 SCLK pulses each 1 cycle high.
- `rst_i` pulsed during the 8th SCLK period of a 0x00FF write:
  - Next cycle: `cs_n`=1, `sclk`=0, `rdy`=1, `dac_code_o`=0.
  - A new write 0x0F0F afterwards completes normally.
- With `DAC_LDAC_EN`, LDAC_CYCLES=2:
  - `dac_ldac_n_o` low for exactly 2 cycles starting the cycle after `cs_n` rises.
  - `rdy` rises at cycle 171.
